muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the RV32M/RV64M extension. It sits beside the single-cycle ALU in the execute stage.
- Accepts one operation over a valid/ready handshake. Computes it bit-serially, one bit per cycle, and holds the result until the consumer takes it.
- Generalises the ALU operation set with width parameterisation and multi-cycle operation.
- A pipeline flush aborts the operation in flight.

---
 rtl/enums_pkg.sv | 51 +++++
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/enums_pkg.sv
// +--------------------------------------------------------------------------+
// | enums_pkg: operation/state encodings and op-decode helpers (muldiv_unit)  |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package enums_pkg;

  typedef enum logic [2:0] {
    MULDIV_MUL,
    MULDIV_MULH,
    MULDIV_MULHSU,
    MULDIV_MULHU,
    MULDIV_DIV,
    MULDIV_DIVU,
    MULDIV_REM,
    MULDIV_REMU
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return (op == MULDIV_REM) || (op == MULDIV_REMU);
  endfunction

  function automatic logic a_signed(input muldiv_op_t op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
           (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

  function automatic logic b_signed(input muldiv_op_t op);
    return (op == MULDIV_MUL) || (op == MULDIV_MULH) ||
           (op == MULDIV_DIV) || (op == MULDIV_REM);
  endfunction

  function automatic logic want_high(input muldiv_op_t op);
    return (op == MULDIV_MULH) || (op == MULDIV_MULHSU) || (op == MULDIV_MULHU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// +--------------------------------------------------------------------------+
// | muldiv_unit: bit-serial RV32M/RV64M multiply/divide with valid/ready I/O  |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module muldiv_unit
  import enums_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  muldiv_op_t      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  muldiv_op_t        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_result;
  logic [2*XLEN-1:0] r_acc;

  logic              w_accept;
  logic              w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_abs, w_b_abs;
  logic              w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [XLEN:0]     w_div_trial;
  logic [2*XLEN-1:0] w_div_nxt;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_div_sel, w_fix_res;

  assign in_ready   = (r_state == MD_IDLE) && !flush;
  assign out_valid  = (r_state == MD_DONE);
  assign busy       = (r_state != MD_IDLE);
  assign out_result = r_result;
  assign w_accept   = in_valid && in_ready;

  // Operand magnitudes and special-case detection on the incoming request
  assign w_a_neg    = a_signed(in_op) && in_a[XLEN-1];
  assign w_b_neg    = b_signed(in_op) && in_b[XLEN-1];
  assign w_a_abs    = w_a_neg ? (~in_a + 1'b1) : in_a;
  assign w_b_abs    = w_b_neg ? (~in_b + 1'b1) : in_b;
  assign w_div_zero = is_div(in_op) && (in_b == '0);
  assign w_ovf      = is_div(in_op) && a_signed(in_op) && (in_a == c_int_min) && (in_b == '1);
  assign w_special  = w_div_zero || w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) w_special_res = is_rem(in_op) ? in_a : '1;
    else            w_special_res = is_rem(in_op) ? '0 : in_a;
  end

  // Multiply: shift-add with the multiplier in the low half of the accumulator
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
  assign w_mul_nxt = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

  // Divide: restoring; high half is the remainder, low half shifts dividend out / quotient in.
  // The MSB of the trial difference is the borrow.
  assign w_div_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_opnd};
  assign w_div_nxt   = w_div_trial[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                         : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prod_fix = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_div_sel  = is_rem(r_op) ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

  always_comb begin
    w_fix_res = '0;
    if (is_div(r_op))       w_fix_res = r_neg ? (~w_div_sel + 1'b1) : w_div_sel;
    else if (want_high(r_op)) w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
    else                    w_fix_res = w_prod_fix[XLEN-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (w_accept) w_state_nxt = w_special ? MD_DONE : MD_CALC;
      MD_CALC: if (r_cnt == '0) w_state_nxt = MD_FIX;
      MD_FIX:  w_state_nxt = MD_DONE;
      MD_DONE: if (out_ready) w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
    if (flush) w_state_nxt = MD_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_op     <= MULDIV_MUL;
      r_neg    <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= in_op;
        r_cnt <= CNT_W'(XLEN-1);
        // Remainder takes the dividend's sign; everything else the XOR of both
        r_neg <= is_rem(in_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
        if (is_div(in_op)) begin
          r_opnd <= w_b_abs;
          r_acc  <= {{XLEN{1'b0}}, w_a_abs};
        end else begin
          r_opnd <= w_a_abs;
          r_acc  <= {{XLEN{1'b0}}, w_b_abs};
        end
        if (w_special) r_result <= w_special_res;
      end
      if (r_state == MD_CALC) begin
        r_acc <= is_div(r_op) ? w_div_nxt : w_mul_nxt;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == MD_FIX) r_result <= w_fix_res;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// +--------------------------------------------------------------------------+
// | tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=32)    |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_unit;
  import enums_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  muldiv_op_t  in_op = MULDIV_MUL;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Issue one request, then count negedges until out_valid; lat=-1 on timeout
  task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int ready_hi);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    ready_hi = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      if (in_ready) ready_hi++;
    end
    res = out_result;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result got %h want 0", out_result); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] res; int lat; int rh;
    run_op(MULDIV_MUL, 32'd7, 32'hFFFF_FFFD, res, lat, rh);
    n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result got %h want ffffffeb", res); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL mul_latency got %0d want 34", lat); end
    n_checks++; if (rh != 0) begin n_fail++; $display("FAIL mul_in_ready_low got %0d high cycles want 0", rh); end
    consume();
    run_op(MULDIV_MULH, 32'h8000_0000, 32'h8000_0000, res, lat, rh);
    n_checks++; if (res !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh got %h want 40000000", res); end
    consume();
    run_op(MULDIV_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, rh);
    n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu got %h want fffffffe", res); end
    consume();
    run_op(MULDIV_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, rh);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu got %h want ffffffff", res); end
    consume();
  endtask

  task automatic test_div();
    logic [31:0] res; int lat; int rh;
    run_op(MULDIV_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, rh);
    n_checks++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div got %h want fffffffd", res); end
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL div_latency got %0d want 34", lat); end
    consume();
    run_op(MULDIV_REM, 32'hFFFF_FFF9, 32'd2, res, lat, rh);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem got %h want ffffffff", res); end
    consume();
    run_op(MULDIV_DIVU, 32'd100, 32'd7, res, lat, rh);
    n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu got %h want 0000000e", res); end
    consume();
    run_op(MULDIV_REMU, 32'd100, 32'd7, res, lat, rh);
    n_checks++; if (res !== 32'd2) begin n_fail++; $display("FAIL remu got %h want 00000002", res); end
    consume();
  endtask

  task automatic test_special();
    logic [31:0] res; int lat; int rh;
    run_op(MULDIV_DIV, 32'd5, 32'd0, res, lat, rh);
    n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_by_zero got %h want ffffffff", res); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL div_by_zero_latency got %0d want 1", lat); end
    consume();
    run_op(MULDIV_REMU, 32'd5, 32'd0, res, lat, rh);
    n_checks++; if (res !== 32'd5) begin n_fail++; $display("FAIL remu_by_zero got %h want 00000005", res); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL remu_by_zero_latency got %0d want 1", lat); end
    consume();
    run_op(MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rh);
    n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow got %h want 80000000", res); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL div_overflow_latency got %0d want 1", lat); end
    consume();
    run_op(MULDIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rh);
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL rem_overflow got %h want 00000000", res); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL rem_overflow_latency got %0d want 1", lat); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat; int rh; int bad;
    run_op(MULDIV_MUL, 32'd3, 32'd5, res, lat, rh);
    n_checks++; if (res !== 32'd15) begin n_fail++; $display("FAIL bp_result got %h want 0000000f", res); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_result !== 32'd15 || in_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0 (last valid=%b res=%h rdy=%b)", bad, out_valid, out_result, in_ready); end
    consume();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat; int rh; int seen;
    @(negedge clk);
    in_op = MULDIV_DIVU; in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy got %b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_out_valid got %0d valid cycles want 0", seen); end
    // Flush in IDLE masks in_ready and blocks acceptance
    flush = 1'b1; in_valid = 1'b1; in_op = MULDIV_MUL;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_idle_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_accept got busy=%b want 0", busy); end
    run_op(MULDIV_DIVU, 32'd9, 32'd3, res, lat, rh);
    n_checks++; if (res !== 32'd3) begin n_fail++; $display("FAIL post_flush_divu got %h want 00000003", res); end
    consume();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_op = MULDIV_MUL; in_a = 32'd11; in_b = 32'd13; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL arst_out_result got %h want 0", out_result); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
